// File: rtl/data_memory_hs.sv
// MEM-stage data memory with valid/ready request handshake, byte/halfword/word
// accesses, load sign/zero extension, fault detection and configurable wait
// states before a single-cycle registered response.
module data_memory_hs #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  MemWrite_i,
  input  logic                  MemRead_i,
  input  logic [2:0]            funct3_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t                  state, state_nx;
  logic [3:0]              wait_cnt, wait_cnt_nx;

  logic                    accept;
  logic                    is_store;
  logic                    size_ok, align_ok, fault;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [1:0]              lane;
  logic [3:0]              byte_en;
  logic [DATA_WIDTH-1:0]   wr_word;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   word_q;
  logic [1:0]              lane_q;
  logic [2:0]              f3_q;
  logic                    load_q, fault_q;
  logic [DATA_WIDTH-1:0]   rd_last;
  logic                    err_last;

  logic [7:0]              sel_b;
  logic [15:0]             sel_h;
  logic [DATA_WIDTH-1:0]   load_ext, rsp_data;

  // Upper address bits beyond the array are deliberately ignored (wrap-around).
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^mem_addr_i[DATA_WIDTH-1:ADDR_WIDTH+2];

  assign word_idx = mem_addr_i[ADDR_WIDTH+1:2];
  assign lane     = mem_addr_i[1:0];
  assign is_store = MemWrite_i;
  assign accept   = !rst && (state == ST_IDLE) && req_valid_i && (MemRead_i || MemWrite_i);

  // Size legality and alignment decode; stores only allow the signed size codes.
  always_comb begin
    size_ok  = 1'b0;
    align_ok = 1'b1;
    case (funct3_i)
      3'b000: size_ok = 1'b1;
      3'b001: begin size_ok = 1'b1;      align_ok = ~mem_addr_i[0]; end
      3'b010: begin size_ok = 1'b1;      align_ok = (mem_addr_i[1:0] == 2'b00); end
      3'b100: size_ok = !is_store;
      3'b101: begin size_ok = !is_store; align_ok = ~mem_addr_i[0]; end
      default: size_ok = 1'b0;
    endcase
    fault = !(size_ok && align_ok);
  end

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    byte_en = 4'b1111;
    wr_word = wr_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_word = {4{wr_data_i[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wr_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Array write on accepted legal stores; loads capture the addressed word.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (is_store) begin
        if (!fault) begin
          if (byte_en[0]) mem[word_idx][7:0]   <= wr_word[7:0];
          if (byte_en[1]) mem[word_idx][15:8]  <= wr_word[15:8];
          if (byte_en[2]) mem[word_idx][23:16] <= wr_word[23:16];
          if (byte_en[3]) mem[word_idx][31:24] <= wr_word[31:24];
        end
      end else begin
        word_q <= mem[word_idx];
      end
    end
  end

  // State, wait counter, captured request attributes and held response values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      lane_q   <= '0;
      f3_q     <= '0;
      load_q   <= 1'b0;
      fault_q  <= 1'b0;
      rd_last  <= '0;
      err_last <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (accept) begin
        lane_q  <= lane;
        f3_q    <= funct3_i;
        load_q  <= !is_store;
        fault_q <= fault;
      end
      if (state == ST_RESP) begin
        rd_last  <= rsp_data;
        err_last <= fault_q;
      end
    end
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nx    = ST_WAIT;
            wait_cnt_nx = WS_LOAD;
          end else begin
            state_nx = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) state_nx = ST_RESP;
        else                  wait_cnt_nx = wait_cnt - 4'd1;
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Lane select and sign/zero extension of the captured load word.
  always_comb begin
    case (lane_q)
      2'd0:    sel_b = word_q[7:0];
      2'd1:    sel_b = word_q[15:8];
      2'd2:    sel_b = word_q[23:16];
      default: sel_b = word_q[31:24];
    endcase
    sel_h = lane_q[1] ? word_q[31:16] : word_q[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{sel_b[7]}}, sel_b};
      3'b001:  load_ext = {{16{sel_h[15]}}, sel_h};
      3'b010:  load_ext = word_q;
      3'b100:  load_ext = {24'd0, sel_b};
      3'b101:  load_ext = {16'd0, sel_h};
      default: load_ext = '0;
    endcase
    rsp_data = (load_q && !fault_q) ? load_ext : '0;
  end

  assign req_ready_o = (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_RESP);
  assign rd_data_o   = (state == ST_RESP) ? rsp_data : rd_last;
  assign err_o       = (state == ST_RESP) ? fault_q  : err_last;

endmodule

// File: tb/tb_data_memory_hs.sv
// Self-checking bench for data_memory_hs: one instance with no wait states and
// one with three, driven by a reference memory model and response scoreboards.
module tb_data_memory_hs;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v3 = 1'b0;
  logic [31:0] addr = '0, wd = '0;
  logic        mw = 1'b0, mr = 1'b0;
  logic [2:0]  f3 = '0;
  logic        r0, rv0, e0, r3, rv3, e3;
  logic [31:0] rd0, rd3;

  typedef struct {
    string       nm;
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
  } op_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        q0[$], q3[$];
  logic [31:0] mm0[int], mm3[int];

  always #5 clk = ~clk;

  data_memory_hs #(.DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid_i(v0), .req_ready_o(r0),
    .mem_addr_i(addr), .wr_data_i(wd), .MemWrite_i(mw), .MemRead_i(mr),
    .funct3_i(f3), .rsp_valid_o(rv0), .rd_data_o(rd0), .err_o(e0)
  );

  data_memory_hs #(.DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid_i(v3), .req_ready_o(r3),
    .mem_addr_i(addr), .wr_data_i(wd), .MemWrite_i(mw), .MemRead_i(mr),
    .funct3_i(f3), .rsp_valid_o(rv3), .rd_data_o(rd3), .err_o(e3)
  );

  function automatic op_t mk(string nm, bit rd, bit wr, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    op_t o;
    o.nm = nm; o.rd = rd; o.wr = wr; o.f3 = f; o.a = a; o.d = d;
    return o;
  endfunction

  // Reference behaviour of one request against the current word contents.
  function automatic void predict(input logic [31:0] w, input op_t o, output exp_t e, output logic [31:0] nw);
    logic        legal, aligned;
    logic [31:0] b, h;
    nw = w;
    if (o.wr) legal = o.f3 inside {3'd0, 3'd1, 3'd2};
    else      legal = o.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    aligned = 1'b1;
    if (o.f3[1:0] == 2'd1)      aligned = (o.a[0] == 1'b0);
    else if (o.f3[1:0] == 2'd2) aligned = (o.a[1:0] == 2'd0);
    e.e = !(legal && aligned);
    e.d = '0;
    if (e.e) return;
    if (o.wr) begin
      case (o.f3)
        3'd0:    nw[8*o.a[1:0] +: 8]  = o.d[7:0];
        3'd1:    nw[16*o.a[1] +: 16]  = o.d[15:0];
        default: nw = o.d;
      endcase
    end else begin
      b = w >> (8 * o.a[1:0]);
      h = w >> (16 * o.a[1]);
      case (o.f3)
        3'd0:    e.d = {{24{b[7]}}, b[7:0]};
        3'd1:    e.d = {{16{h[15]}}, h[15:0]};
        3'd2:    e.d = w;
        3'd4:    e.d = {24'd0, b[7:0]};
        default: e.d = {16'd0, h[15:0]};
      endcase
    end
  endfunction

  function automatic logic rdy(int sel);
    return (sel == 3) ? r3 : r0;
  endfunction

  function automatic logic rsv(int sel);
    return (sel == 3) ? rv3 : rv0;
  endfunction

  task automatic set_valid(input int sel, input logic b);
    if (sel == 3) v3 = b; else v0 = b;
  endtask

  // Update the reference memory and push the expected response.
  task automatic model_push(input int sel, input op_t o);
    exp_t        e;
    logic [31:0] w, nw;
    int          idx;
    idx = int'((o.a >> 2) % DEPTH);
    if (sel == 3) w = mm3.exists(idx) ? mm3[idx] : 'x;
    else          w = mm0.exists(idx) ? mm0[idx] : 'x;
    predict(w, o, e, nw);
    if (o.wr && !e.e) begin
      if (sel == 3) mm3[idx] = nw; else mm0[idx] = nw;
    end
    if (sel == 3) q3.push_back(e); else q0.push_back(e);
  endtask

  task automatic drive_inputs(input op_t o);
    addr = o.a; wd = o.d; mr = o.rd; mw = o.wr; f3 = o.f3;
  endtask

  // Present a request and return #1 after the edge on which it was accepted.
  task automatic issue(input int sel, input op_t o, output bit ok);
    model_push(sel, o);
    @(negedge clk);
    drive_inputs(o);
    set_valid(sel, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rdy(sel)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    set_valid(sel, 1'b0);
  endtask

  // Collect the next response; lat counts cycles after acceptance, -1 on timeout.
  task automatic wait_rsp(input int sel, output logic [31:0] d, output logic e, output int lat);
    lat = -1; d = 'x; e = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsv(sel)) begin
        d   = (sel == 3) ? rd3 : rd0;
        e   = (sel == 3) ? e3 : e0;
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({r0, rv0, e0, rd0} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_ws0: ready=%b valid=%b err=%b data=%h, expected 1 0 0 00000000", r0, rv0, e0, rd0);
    end
    n_checks++;
    if ({r3, rv3, e3, rd3} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_ws3: ready=%b valid=%b err=%b data=%h, expected 1 0 0 00000000", r3, rv3, e3, rd3);
    end
    rst = 1'b0;
  endtask

  task automatic run_ws0(input string tag, input op_t ops[$]);
    bit          ok;
    logic [31:0] gd;
    logic        ge;
    int          lat;
    exp_t        ex;
    foreach (ops[k]) begin
      issue(0, ops[k], ok);
      wait_rsp(0, gd, ge, lat);
      ex = q0.pop_front();
      n_checks++;
      if (!ok || lat != 1 || gd !== ex.d || ge !== ex.e) begin
        n_fail++;
        $display("FAIL %s/%s: got data=%h err=%b lat=%0d acc=%0b, expected data=%h err=%b lat=1",
                 tag, ops[k].nm, gd, ge, lat, ok, ex.d, ex.e);
      end
    end
  endtask

  task automatic test_word();
    op_t ops[$];
    ops.push_back(mk("sw_10", 0, 1, 3'd2, 32'h10, 32'hDEADBEEF));
    ops.push_back(mk("lw_10", 1, 0, 3'd2, 32'h10, 32'h0));
    run_ws0("word", ops);
  endtask

  task automatic test_subword();
    op_t ops[$];
    ops.push_back(mk("sw0_20",  0, 1, 3'd2, 32'h20, 32'h0));
    ops.push_back(mk("sb_21",   0, 1, 3'd0, 32'h21, 32'hFFFFFF80));
    ops.push_back(mk("lw_20a",  1, 0, 3'd2, 32'h20, 32'h0));
    ops.push_back(mk("lb_21",   1, 0, 3'd0, 32'h21, 32'h0));
    ops.push_back(mk("lbu_21",  1, 0, 3'd4, 32'h21, 32'h0));
    ops.push_back(mk("sh_22",   0, 1, 3'd1, 32'h22, 32'hABCD1234));
    ops.push_back(mk("lw_20b",  1, 0, 3'd2, 32'h20, 32'h0));
    ops.push_back(mk("lh_22",   1, 0, 3'd1, 32'h22, 32'h0));
    run_ws0("subword", ops);
  endtask

  task automatic test_faults();
    op_t ops[$];
    bit  bad;
    ops.push_back(mk("lw_13_mis",  1, 0, 3'd2, 32'h13, 32'h0));
    ops.push_back(mk("sh_21_mis",  0, 1, 3'd1, 32'h21, 32'h5555));
    ops.push_back(mk("lw_20_kept", 1, 0, 3'd2, 32'h20, 32'h0));
    ops.push_back(mk("sw_30",      0, 1, 3'd2, 32'h30, 32'hCAFEF00D));
    ops.push_back(mk("s100_30",    0, 1, 3'd4, 32'h30, 32'h0));
    ops.push_back(mk("lw_30",      1, 0, 3'd2, 32'h30, 32'h0));
    ops.push_back(mk("l011_30",    1, 0, 3'd3, 32'h30, 32'h0));
    ops.push_back(mk("lh_31_mis",  1, 0, 3'd1, 32'h31, 32'h0));
    ops.push_back(mk("lhu_32",     1, 0, 3'd5, 32'h32, 32'h0));
    ops.push_back(mk("lb_33",      1, 0, 3'd0, 32'h33, 32'h0));
    ops.push_back(mk("rdwr_34",    1, 1, 3'd2, 32'h34, 32'h11223344));
    ops.push_back(mk("lw_34",      1, 0, 3'd2, 32'h34, 32'h0));
    run_ws0("fault", ops);
    // A valid request with neither read nor write must be ignored.
    @(negedge clk);
    mr = 1'b0; mw = 1'b0; v0 = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rv0 !== 1'b0 || r0 !== 1'b1) bad = 1'b1;
    end
    v0 = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL ignored_req: saw response or ready drop (valid=%b ready=%b), expected none", rv0, r0);
    end
  endtask

  task automatic test_wrap();
    op_t ops[$];
    ops.push_back(mk("lw_wrap", 1, 0, 3'd2, 32'(4 * DEPTH + 'h10), 32'h0));
    run_ws0("wrap", ops);
  endtask

  task automatic test_wait_states();
    bit          ok;
    logic [31:0] gd;
    logic        ge;
    int          lat;
    exp_t        ex;
    op_t         st, ld;
    int          pulses[$];
    bit          rdy_bad;
    st = mk("sw_40", 0, 1, 3'd2, 32'h40, 32'hA5A55A5A);
    issue(3, st, ok);
    wait_rsp(3, gd, ge, lat);
    ex = q3.pop_front();
    n_checks++;
    if (!ok || lat != 4 || gd !== ex.d || ge !== ex.e) begin
      n_fail++;
      $display("FAIL ws3/sw_40: got data=%h err=%b lat=%0d, expected data=%h err=%b lat=4", gd, ge, lat, ex.d, ex.e);
    end
    // Two loads with valid held high: second accepted on first IDLE cycle.
    ld = mk("lw_40", 1, 0, 3'd2, 32'h40, 32'h0);
    model_push(3, ld);
    model_push(3, ld);
    @(negedge clk);
    drive_inputs(ld);
    v3 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (r3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    rdy_bad = !ok;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (r3 !== ((i == 5) || (i == 10))) rdy_bad = 1'b1;
      if (rv3 === 1'b1) begin
        pulses.push_back(i);
        ex = (q3.size() > 0) ? q3.pop_front() : '{d: 32'hx, e: 1'bx};
        n_checks++;
        if (rd3 !== ex.d || e3 !== ex.e) begin
          n_fail++;
          $display("FAIL ws3/b2b_data@%0d: got data=%h err=%b, expected data=%h err=%b", i, rd3, e3, ex.d, ex.e);
        end
      end
      if (i == 6) v3 = 1'b0;
    end
    v3 = 1'b0;
    n_checks++;
    if (rdy_bad) begin
      n_fail++;
      $display("FAIL ws3/ready_pattern: ready not low 4 cycles after each acceptance, expected high only at cycles 5 and 10");
    end
    n_checks++;
    if (pulses.size() != 2 || pulses[0] != 4 || pulses[1] != 9) begin
      n_fail++;
      $display("FAIL ws3/pulse_cycles: got %0d pulses (first=%0d), expected 2 pulses at cycles 4 and 9",
               pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
    end
    q3.delete();
  endtask

  task automatic test_reset_mid();
    bit          ok, bad;
    logic [31:0] gd;
    logic        ge;
    int          lat;
    exp_t        ex;
    op_t         st, ld, st2;
    st  = mk("sw_50", 0, 1, 3'd2, 32'h50, 32'h0BADCAFE);
    ld  = mk("lw_50", 1, 0, 3'd2, 32'h50, 32'h0);
    st2 = mk("sw_50_rst", 0, 1, 3'd2, 32'h50, 32'hFFFFFFFF);
    issue(3, st, ok);
    void'(q3.pop_front());
    bad = !ok;
    @(negedge clk);
    if (rv3 !== 1'b0) bad = 1'b1;
    @(negedge clk);
    if (rv3 !== 1'b0) bad = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (r3 !== 1'b1 || rv3 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid/ready_after: ready=%b valid=%b, expected ready=1 valid=0", r3, rv3);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rv3 !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL rst_mid/dropped: response pulse seen or store not accepted, expected none after reset");
    end
    // Request presented together with rst must not be accepted.
    drive_inputs(st2);
    v3  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v3  = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rv3 !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL rst_same_cycle: response seen for request presented with rst, expected none");
    end
    issue(3, ld, ok);
    wait_rsp(3, gd, ge, lat);
    ex = q3.pop_front();
    n_checks++;
    if (!ok || lat != 4 || gd !== ex.d || ge !== ex.e) begin
      n_fail++;
      $display("FAIL rst_mid/readback: got data=%h err=%b lat=%0d, expected data=%h err=%b lat=4", gd, ge, lat, ex.d, ex.e);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_faults();
    test_wrap();
    test_wait_states();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
